ifu_ar_grant_arbiter: RTL and testbench

Round-robin grant arbiter that shares the arbiter-side AXI write path (wr_avalid/wr_adata/wr_adone stream) between the IFU and other fill requesters, such as weight and feature loaders. Each requester raises a grant request. The block issues one registered, one-hot grant and holds it until the owner signals done. After release it inserts a one-cycle bus-turnaround gap. It sits between the requesters' grant_rqst/grant pins and the shared arbiter.

---
 rtl/ifu_ar_grant_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_ifu_ar_grant_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_ar_grant_arbiter.sv
// -----------------------------------------------------------------------------
// ifu_ar_grant_arbiter
//
// Round-robin grant arbiter sharing the arbiter-side AXI write path between the
// IFU (requester 0) and the other fill requesters (weight/feature loaders).
// One registered one-hot grant is issued and held until the owner releases it
// by pulsing done[owner] or dropping req[owner]. Every release is followed by a
// single turnaround cycle with no grant. Arbitration runs in that turnaround
// cycle, so a waiting requester sees its grant two cycles after the done pulse.
//
// Optional feature (compile-time macro): ARB_TIMEOUT_EN
//   defined   : a grant still held when hold_cnt reaches MAX_HOLD-1 is revoked
//               like a normal release and timeout_irq pulses for one cycle,
//               coincident with grant falling.
//   undefined : no watchdog, grants are held indefinitely, timeout_irq stays 0.
//
// Ports
//   clk          in   system clock, rising edge
//   rstn         in   asynchronous reset, ACTIVE HIGH (name kept from codebase)
//   req          in   [NUM_REQ]   per-requester level request, bit 0 = IFU
//   done         in   [NUM_REQ]   per-requester release pulse, owner bit only
//   grant        out  [NUM_REQ]   registered one-hot grant, bit 0 = IFU
//   grant_id     out  [ID_WIDTH]  binary index of current owner, 0 when idle
//   busy         out              a grant is held
//   hold_cnt     out  [CNT_WIDTH] cycles held by the current owner, saturating
//   timeout_irq  out              one-cycle watchdog revoke pulse
//
// FSM
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | no grant, arbitrate every cycle
//   S_GRANT   | grant held by grant_id, count hold cycles, watch for release
//   S_RELEASE | one-cycle turnaround with grant low, arbitrate for next owner
// -----------------------------------------------------------------------------
module ifu_ar_grant_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int MAX_HOLD  = 256,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   grant,
  output logic [ID_WIDTH-1:0]  grant_id,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] hold_cnt,
  output logic                 timeout_irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]  ONE_HOT0 = NUM_REQ'(1);

  state_t               state_q;
  state_t               state_d;
  logic [ID_WIDTH-1:0]  last_ptr_q;
  logic [ID_WIDTH-1:0]  last_ptr_d;

  logic [NUM_REQ-1:0]   grant_d;
  logic [ID_WIDTH-1:0]  grant_id_d;
  logic                 busy_d;
  logic [CNT_WIDTH-1:0] hold_cnt_d;
  logic                 timeout_d;

  logic                 pick_valid;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 owner_done;
  logic                 owner_drop;
  logic                 wd_hit;
  logic                 release_evt;

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan upward from last_ptr+1, wrapping at NUM_REQ-1, and
  // take the first requester found. The wrap is explicit so NUM_REQ need not be
  // a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [ID_WIDTH-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = (last_ptr_q == LAST_IDX) ? '0 : last_ptr_q + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
  end

  // Only the owner's own bits matter; everyone else's done/req are ignored
  // while a grant is held, so there is no preemption.
  assign owner_done = done[grant_id];
  assign owner_drop = ~req[grant_id];

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(MAX_HOLD - 1);
  assign wd_hit = (hold_cnt == WD_LAST);
`else
  assign wd_hit = 1'b0;
`endif

  assign release_evt = owner_done | owner_drop | wd_hit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (release_evt) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = pick_valid ? S_GRANT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values. All outputs are registered below so the
  // grant seen by requesters is glitch-free.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_d    = grant;
    grant_id_d = grant_id;
    busy_d     = busy;
    hold_cnt_d = hold_cnt;
    last_ptr_d = last_ptr_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        // last_ptr already holds the previous owner here, so the turnaround
        // cycle arbitrates with the updated pointer.
        if (pick_valid) begin
          grant_d    = ONE_HOT0 << pick_idx;
          grant_id_d = pick_idx;
          busy_d     = 1'b1;
        end else begin
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
        end
        hold_cnt_d = '0;
      end
      S_GRANT: begin
        if (release_evt) begin
          grant_d    = '0;
          grant_id_d = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          last_ptr_d = grant_id;
          // A watchdog revoke only counts as a timeout when the owner did not
          // release on its own in the same cycle.
          timeout_d  = wd_hit & ~owner_done & ~owner_drop;
        end else if (hold_cnt != '1) begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      default: begin
        grant_d    = '0;
        grant_id_d = '0;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and pointer registers. Pointer resets to the last index so that
  // requester 0 (the IFU) wins the first arbitration.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      grant       <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      hold_cnt    <= '0;
      timeout_irq <= 1'b0;
      last_ptr_q  <= LAST_IDX;
    end else begin
      grant       <= grant_d;
      grant_id    <= grant_id_d;
      busy        <= busy_d;
      hold_cnt    <= hold_cnt_d;
      timeout_irq <= timeout_d;
      last_ptr_q  <= last_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants of the grant outputs.
  // ---------------------------------------------------------------------------
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rstn)
    $onehot0(grant));

  a_busy_matches_grant : assert property (@(posedge clk) disable iff (rstn)
    busy == (|grant));

  a_id_matches_grant : assert property (@(posedge clk) disable iff (rstn)
    busy |-> (grant == (ONE_HOT0 << grant_id)));

  a_idle_id_zero : assert property (@(posedge clk) disable iff (rstn)
    !busy |-> (grant_id == '0));

  a_irq_with_release : assert property (@(posedge clk) disable iff (rstn)
    timeout_irq |-> !busy);

endmodule

// File: tb/tb_ifu_ar_grant_arbiter.sv
module tb_ifu_ar_grant_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ID_WIDTH  = 2;
  localparam int MAX_HOLD  = 8;
  localparam int CNT_WIDTH = 16;

  logic                 clk  = 1'b0;
  logic                 rstn = 1'b1;
  logic [NUM_REQ-1:0]   req  = '0;
  logic [NUM_REQ-1:0]   done = '0;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_WIDTH-1:0]  grant_id;
  logic                 busy;
  logic [CNT_WIDTH-1:0] hold_cnt;
  logic                 timeout_irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ifu_ar_grant_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH),
    .MAX_HOLD (MAX_HOLD),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .hold_cnt   (hold_cnt),
    .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: an owner index (-1 = nobody), the previous winner, and a
  // hold count. A released owner leaves one empty cycle before anyone can win.
  // ---------------------------------------------------------------------------
  int m_owner = -1;
  int m_ptr   = NUM_REQ - 1;
  int m_hold  = 0;
  bit m_irq   = 0;
  int m_win;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (p + k) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      m_owner = -1;
      m_ptr   = NUM_REQ - 1;
      m_hold  = 0;
      m_irq   = 0;
    end else begin
      m_irq = 0;
      if (m_owner >= 0) begin
        if (done[m_owner] || !req[m_owner]) begin
          m_ptr   = m_owner;
          m_owner = -1;
          m_hold  = 0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_hold == MAX_HOLD - 1) begin
          m_ptr   = m_owner;
          m_owner = -1;
          m_hold  = 0;
          m_irq   = 1;
        end
`endif
        else if (m_hold < (1 << CNT_WIDTH) - 1) begin
          m_hold++;
        end
      end else begin
        m_win = rr_pick(req, m_ptr);
        if (m_win >= 0) begin
          m_owner = m_win;
          m_hold  = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_grant",    grant,       (m_owner >= 0) ? (longint'(1) << m_owner) : 0);
    check("m_grant_id", grant_id,    (m_owner >= 0) ? m_owner : 0);
    check("m_busy",     busy,        (m_owner >= 0) ? 1 : 0);
    check("m_hold_cnt", hold_cnt,    m_hold);
    check("m_irq",      timeout_irq, m_irq);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge; reset is asserted off-edge and released on a negedge.
  task automatic do_reset();
    req  = '0;
    done = '0;
    #2 rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
  endtask

  function automatic logic [NUM_REQ-1:0] rr_seq(input int k);
    logic [NUM_REQ-1:0] one = 1;
    if (k >= 16) return one;
    if (k % 4 == 3) return '0;
    return one << (k / 4);
  endfunction

  logic [NUM_REQ-1:0] exp_g;
  logic [NUM_REQ-1:0] flips;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_grant",    grant,       0);
    check("rst_grant_id", grant_id,    0);
    check("rst_busy",     busy,        0);
    check("rst_hold",     hold_cnt,    0);
    check("rst_irq",      timeout_irq, 0);
    rstn = 1'b0;

    // Single IFU request, release by done, back to idle
    req = 4'b0001;
    step();
    check("t1_grant",    grant,    4'b0001);
    check("t1_grant_id", grant_id, 0);
    check("t1_busy",     busy,     1);
    done = 4'b0001;
    step();
    check("t1_rel_grant", grant, 0);
    check("t1_rel_busy",  busy,  0);
    req  = '0;
    done = '0;
    step(2);
    check("t1_idle_grant", grant, 0);

    // All requesting, each owner releases after 3 cycles
    do_reset();
    req = 4'b1111;
    for (int k = 0; k <= 16; k++) begin
      step();
      exp_g = rr_seq(k);
      check("t2_rr_grant", grant, exp_g);
      if (exp_g != 0) check("t2_rr_hold", hold_cnt, k % 4);
      done = (k % 4 == 2) ? exp_g : '0;
    end
    done = '0;

    // Non-owner done and req activity never disturbs owner 1
    do_reset();
    req = 4'b0010;
    step();
    check("t3_grant", grant, 4'b0010);
    done = 4'b1100;
    req  = 4'b1110;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t3_hold_grant", grant,    4'b0010);
      check("t3_hold_cnt",   hold_cnt, i);
    end
    done = '0;

    // Implicit release by owner 2 dropping req; 3 wins over 0
    do_reset();
    req = 4'b0100;
    step();
    check("t4_grant",    grant,    4'b0100);
    check("t4_grant_id", grant_id, 2);
    req = 4'b1001;
    step();
    check("t4_gap", grant, 0);
    step();
    check("t4_next_grant", grant,    4'b1000);
    check("t4_next_id",    grant_id, 3);

    // Asynchronous reset while holding, then pointer restart at 0
    do_reset();
    req = 4'b0100;
    step(11);
    check("t5_pre_grant", grant,    4'b0100);
    check("t5_pre_hold",  hold_cnt, 10);
    #2 rstn = 1'b1;
    #1;
    check("t5_async_grant", grant,    0);
    check("t5_async_hold",  hold_cnt, 0);
    check("t5_async_busy",  busy,     0);
    @(negedge clk);
    rstn = 1'b0;
    req  = 4'b1111;
    step();
    check("t5_after_grant", grant, 4'b0001);

    // done already high when the grant is issued: one-cycle hold
    do_reset();
    req  = 4'b0001;
    done = 4'b0001;
    step();
    check("t6_grant", grant,    4'b0001);
    check("t6_hold",  hold_cnt, 0);
    step();
    check("t6_rel", grant, 0);
    req  = '0;
    done = '0;
    step();

`ifdef ARB_TIMEOUT_EN
    // Watchdog revoke after MAX_HOLD cycles
    do_reset();
    req = 4'b0011;
    step();
    step(MAX_HOLD - 1);
    check("t7_pre_grant", grant, 4'b0001);
    step();
    check("t7_revoke_grant", grant,       0);
    check("t7_revoke_irq",   timeout_irq, 1);
    step();
    check("t7_irq_pulse", timeout_irq, 0);
    check("t7_next",      grant,       4'b0010);
`endif

    // Randomized traffic; the per-cycle compare does the checking
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      flips = NUM_REQ'($urandom & $urandom & $urandom);
      req   = req ^ flips;
      done  = NUM_REQ'($urandom & $urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
      end else begin
        step();
      end
    end
    req  = '0;
    done = '0;
    step(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
